// File: rtl/axi_interconnect_pkg.sv
// Shared defaults for the AXI interconnect address channel and the layout of
// one order-FIFO entry ({mst_idx, len}). The default build uses fixed-priority
// arbitration. Defining SA_XADDR_RR_EN at compile time selects round-robin.
package axi_interconnect_pkg;

  localparam int unsigned MST_AMT_DEF           = 2;
  localparam int unsigned OUTSTANDING_AMT_DEF   = 8;
  localparam int unsigned ADDR_WIDTH_DEF        = 32;
  localparam int unsigned TRANS_MST_ID_W_DEF    = 5;
  localparam int unsigned TRANS_BURST_W_DEF     = 2;
  localparam int unsigned TRANS_DATA_LEN_W_DEF  = 3;
  localparam int unsigned TRANS_DATA_SIZE_W_DEF = 3;
  localparam int unsigned MST_ID_W_DEF          = $clog2(MST_AMT_DEF);

  // Order-FIFO entry: which master owns the burst, and its AxLEN
  typedef struct packed {
    logic [MST_ID_W_DEF-1:0]         mst_idx;
    logic [TRANS_DATA_LEN_W_DEF-1:0] len;
  } order_entry_t;

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO with an occupancy counter and a show-ahead head output.
// Ports: clk/rst (async active-high), wr_valid_i/data_i push, rd_valid_i pop,
// data_o head entry, empty_o/full_o flags, counter_o occupancy.
// A push is ignored when the FIFO is full, and a pop is ignored when it is empty.
module fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  rd_valid_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [CNT_W-1:0]      counter_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  push_c, pop_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign push_c    = wr_valid_i & ~full_o;
  assign pop_c     = rd_valid_i & ~empty_o;
  assign data_o    = mem_q[rd_ptr_q];
  assign counter_o = cnt_q;

  // Pointer and occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_c) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_c)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_c, pop_c})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_c) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/sa_xaddr_channel.sv
// Slave-side AXI address channel. It arbitrates MST_AMT dispatchers into one
// registered output stage. The order of accepted bursts is kept in a FIFO, so
// the data channel knows which master owns the current burst.
// Ports: ACLK_i/ARESET_i (async active-high); dsp_Ax*_i packed per master
// (master 0 in the LSBs) with dsp_AxREADY_o; s_Ax*_o/s_AxREADY_i to the slave;
// s_xVALID_i/s_xREADY_i data beats; sa_xDATA_mst_id_o head owner;
// sa_xDATA_disable_o no burst outstanding; sa_outst_ctn_o outstanding count.
// The default build uses fixed priority, where the lowest valid index wins.
// Defining SA_XADDR_RR_EN selects round-robin arbitration.
module sa_xaddr_channel
  import axi_interconnect_pkg::*;
#(
  parameter int unsigned MST_AMT           = MST_AMT_DEF,
  parameter int unsigned OUTSTANDING_AMT   = OUTSTANDING_AMT_DEF,
  parameter int unsigned OUTST_CTN_W       = $clog2(OUTSTANDING_AMT) + 1,
  parameter int unsigned ADDR_WIDTH        = ADDR_WIDTH_DEF,
  parameter int unsigned TRANS_MST_ID_W    = TRANS_MST_ID_W_DEF,
  parameter int unsigned TRANS_BURST_W     = TRANS_BURST_W_DEF,
  parameter int unsigned TRANS_DATA_LEN_W  = TRANS_DATA_LEN_W_DEF,
  parameter int unsigned TRANS_DATA_SIZE_W = TRANS_DATA_SIZE_W_DEF,
  parameter int unsigned MST_ID_W          = $clog2(MST_AMT)
) (
  input  logic                                   ACLK_i,
  input  logic                                   ARESET_i,
  input  logic [MST_AMT*TRANS_MST_ID_W-1:0]      dsp_AxID_i,
  input  logic [MST_AMT*ADDR_WIDTH-1:0]          dsp_AxADDR_i,
  input  logic [MST_AMT*TRANS_BURST_W-1:0]       dsp_AxBURST_i,
  input  logic [MST_AMT*TRANS_DATA_LEN_W-1:0]    dsp_AxLEN_i,
  input  logic [MST_AMT*TRANS_DATA_SIZE_W-1:0]   dsp_AxSIZE_i,
  input  logic [MST_AMT-1:0]                     dsp_AxVALID_i,
  output logic [MST_AMT-1:0]                     dsp_AxREADY_o,
  output logic [MST_ID_W+TRANS_MST_ID_W-1:0]     s_AxID_o,
  output logic [ADDR_WIDTH-1:0]                  s_AxADDR_o,
  output logic [TRANS_BURST_W-1:0]               s_AxBURST_o,
  output logic [TRANS_DATA_LEN_W-1:0]            s_AxLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]           s_AxSIZE_o,
  output logic                                   s_AxVALID_o,
  input  logic                                   s_AxREADY_i,
  input  logic                                   s_xVALID_i,
  input  logic                                   s_xREADY_i,
  output logic [MST_ID_W-1:0]                    sa_xDATA_mst_id_o,
  output logic                                   sa_xDATA_disable_o,
  output logic [OUTST_CTN_W-1:0]                 sa_outst_ctn_o
);

  localparam int unsigned ENTRY_W = MST_ID_W + TRANS_DATA_LEN_W;

  logic                          stage_free_c, accept_c, fifo_full, fifo_empty;
  logic [MST_ID_W-1:0]           grant_idx_c;
  logic [TRANS_MST_ID_W-1:0]     id_c;
  logic [ADDR_WIDTH-1:0]         addr_c;
  logic [TRANS_BURST_W-1:0]      burst_c;
  logic [TRANS_DATA_LEN_W-1:0]   len_c;
  logic [TRANS_DATA_SIZE_W-1:0]  size_c;

  logic                                s_valid_q, s_valid_d;
  logic [MST_ID_W+TRANS_MST_ID_W-1:0]  s_id_q, s_id_d;
  logic [ADDR_WIDTH-1:0]               s_addr_q, s_addr_d;
  logic [TRANS_BURST_W-1:0]            s_burst_q, s_burst_d;
  logic [TRANS_DATA_LEN_W-1:0]         s_len_q, s_len_d;
  logic [TRANS_DATA_SIZE_W-1:0]        s_size_q, s_size_d;

  logic [TRANS_DATA_LEN_W-1:0]   beat_q, beat_d;
  logic                          beat_hs_c, pop_c;
  logic [ENTRY_W-1:0]            head_c;
  logic [MST_ID_W-1:0]           head_idx_c;
  logic [TRANS_DATA_LEN_W-1:0]   head_len_c;

  assign stage_free_c = ~s_valid_q | s_AxREADY_i;
  // Reset gates the accept path so that no handshake is seen while ARESET_i is high
  assign accept_c     = stage_free_c & (|dsp_AxVALID_i) & ~fifo_full & ~ARESET_i;

`ifdef SA_XADDR_RR_EN
  logic [MST_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [MST_AMT-1:0]  rot_valid_c;
  logic                found_c;

  // Rotate the requests so that the pointer position is checked first, then map back
  always_comb begin
    rot_valid_c = MST_AMT'({dsp_AxVALID_i, dsp_AxVALID_i} >> rr_ptr_q);
    grant_idx_c = '0;
    found_c     = 1'b0;
    for (int i = 0; i < int'(MST_AMT); i++) begin
      if (!found_c && rot_valid_c[i]) begin
        found_c     = 1'b1;
        grant_idx_c = MST_ID_W'((i + int'(rr_ptr_q)) % int'(MST_AMT));
      end
    end
  end

  // After a grant to master k, master k+1 gets the highest priority
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept_c)
      rr_ptr_d = (grant_idx_c == MST_ID_W'(MST_AMT - 1)) ? '0 : grant_idx_c + 1'b1;
  end

  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) rr_ptr_q <= '0;
    else          rr_ptr_q <= rr_ptr_d;
  end
`else
  // Fixed priority: the lowest-index valid master wins
  always_comb begin
    grant_idx_c = '0;
    for (int i = int'(MST_AMT) - 1; i >= 0; i--) begin
      if (dsp_AxVALID_i[i]) grant_idx_c = MST_ID_W'(i);
    end
  end
`endif

  // Select the granted master's fields
  always_comb begin
    id_c    = '0;
    addr_c  = '0;
    burst_c = '0;
    len_c   = '0;
    size_c  = '0;
    for (int i = 0; i < int'(MST_AMT); i++) begin
      if (grant_idx_c == MST_ID_W'(i)) begin
        id_c    = dsp_AxID_i[i*TRANS_MST_ID_W +: TRANS_MST_ID_W];
        addr_c  = dsp_AxADDR_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        burst_c = dsp_AxBURST_i[i*TRANS_BURST_W +: TRANS_BURST_W];
        len_c   = dsp_AxLEN_i[i*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
        size_c  = dsp_AxSIZE_i[i*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
      end
    end
  end

  always_comb begin
    dsp_AxREADY_o = '0;
    if (accept_c) dsp_AxREADY_o = MST_AMT'(1) << grant_idx_c;
  end

  // Output stage: load on accept (even during a slave handshake), else drain on handshake
  always_comb begin
    s_valid_d = s_valid_q;
    s_id_d    = s_id_q;
    s_addr_d  = s_addr_q;
    s_burst_d = s_burst_q;
    s_len_d   = s_len_q;
    s_size_d  = s_size_q;
    if (accept_c) begin
      s_valid_d = 1'b1;
      s_id_d    = {grant_idx_c, id_c};
      s_addr_d  = addr_c;
      s_burst_d = burst_c;
      s_len_d   = len_c;
      s_size_d  = size_c;
    end else if (s_AxREADY_i) begin
      s_valid_d = 1'b0;
    end
  end

  // Beat counter walks the head burst, then wraps to zero on its last beat
  assign head_idx_c = head_c[ENTRY_W-1 -: MST_ID_W];
  assign head_len_c = head_c[TRANS_DATA_LEN_W-1:0];
  assign beat_hs_c  = s_xVALID_i & s_xREADY_i & ~fifo_empty;
  assign pop_c      = beat_hs_c & (beat_q == head_len_c);

  always_comb begin
    beat_d = beat_q;
    if (pop_c)          beat_d = '0;
    else if (beat_hs_c) beat_d = beat_q + 1'b1;
  end

  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) begin
      s_valid_q <= 1'b0;
      s_id_q    <= '0;
      s_addr_q  <= '0;
      s_burst_q <= '0;
      s_len_q   <= '0;
      s_size_q  <= '0;
      beat_q    <= '0;
    end else begin
      s_valid_q <= s_valid_d;
      s_id_q    <= s_id_d;
      s_addr_q  <= s_addr_d;
      s_burst_q <= s_burst_d;
      s_len_q   <= s_len_d;
      s_size_q  <= s_size_d;
      beat_q    <= beat_d;
    end
  end

  fifo #(
    .DATA_WIDTH (ENTRY_W),
    .FIFO_DEPTH (OUTSTANDING_AMT),
    .CNT_W      (OUTST_CTN_W)
  ) u_order_fifo (
    .clk        (ACLK_i),
    .rst        (ARESET_i),
    .wr_valid_i (accept_c),
    .data_i     ({grant_idx_c, len_c}),
    .rd_valid_i (pop_c),
    .data_o     (head_c),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .counter_o  (sa_outst_ctn_o)
  );

  assign s_AxVALID_o        = s_valid_q;
  assign s_AxID_o           = s_id_q;
  assign s_AxADDR_o         = s_addr_q;
  assign s_AxBURST_o        = s_burst_q;
  assign s_AxLEN_o          = s_len_q;
  assign s_AxSIZE_o         = s_size_q;
  assign sa_xDATA_mst_id_o  = head_idx_c;
  assign sa_xDATA_disable_o = fifo_empty;

endmodule

// File: tb/tb_sa_xaddr_channel.sv
// Directed bench for sa_xaddr_channel with default parameters (2 masters).
// Accepted requests are queued as expected slave-side fields. They are then
// compared on each cycle the stage is valid, and popped on the slave handshake.
// A second queue holds the expected burst order for the data-side outputs.
// Expected arbitration follows SA_XADDR_RR_EN in the same way as the design.
module tb_sa_xaddr_channel;

  logic        clk = 1'b0;
  logic        ARESET_i;
  logic [1:0]  valid;
  logic [4:0]  b_id    [2];
  logic [31:0] b_addr  [2];
  logic [1:0]  b_burst [2];
  logic [2:0]  b_len   [2];
  logic [2:0]  b_size  [2];

  logic [9:0]  dsp_AxID;
  logic [63:0] dsp_AxADDR;
  logic [3:0]  dsp_AxBURST;
  logic [5:0]  dsp_AxLEN;
  logic [5:0]  dsp_AxSIZE;
  logic [1:0]  dsp_AxREADY_o;
  logic [5:0]  s_AxID_o;
  logic [31:0] s_AxADDR_o;
  logic [1:0]  s_AxBURST_o;
  logic [2:0]  s_AxLEN_o;
  logic [2:0]  s_AxSIZE_o;
  logic        s_AxVALID_o;
  logic        s_AxREADY_i;
  logic        s_xVALID_i;
  logic        s_xREADY_i;
  logic        sa_xDATA_mst_id_o;
  logic        sa_xDATA_disable_o;
  logic [3:0]  sa_outst_ctn_o;

  always #5 clk = ~clk;

  always_comb begin
    dsp_AxID    = {b_id[1], b_id[0]};
    dsp_AxADDR  = {b_addr[1], b_addr[0]};
    dsp_AxBURST = {b_burst[1], b_burst[0]};
    dsp_AxLEN   = {b_len[1], b_len[0]};
    dsp_AxSIZE  = {b_size[1], b_size[0]};
  end

  sa_xaddr_channel dut (
    .ACLK_i             (clk),
    .ARESET_i           (ARESET_i),
    .dsp_AxID_i         (dsp_AxID),
    .dsp_AxADDR_i       (dsp_AxADDR),
    .dsp_AxBURST_i      (dsp_AxBURST),
    .dsp_AxLEN_i        (dsp_AxLEN),
    .dsp_AxSIZE_i       (dsp_AxSIZE),
    .dsp_AxVALID_i      (valid),
    .dsp_AxREADY_o      (dsp_AxREADY_o),
    .s_AxID_o           (s_AxID_o),
    .s_AxADDR_o         (s_AxADDR_o),
    .s_AxBURST_o        (s_AxBURST_o),
    .s_AxLEN_o          (s_AxLEN_o),
    .s_AxSIZE_o         (s_AxSIZE_o),
    .s_AxVALID_o        (s_AxVALID_o),
    .s_AxREADY_i        (s_AxREADY_i),
    .s_xVALID_i         (s_xVALID_i),
    .s_xREADY_i         (s_xREADY_i),
    .sa_xDATA_mst_id_o  (sa_xDATA_mst_id_o),
    .sa_xDATA_disable_o (sa_xDATA_disable_o),
    .sa_outst_ctn_o     (sa_outst_ctn_o)
  );

  typedef struct packed {
    logic [5:0]  id;
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [2:0]  len;
    logic [2:0]  size;
  } sb_t;

  typedef struct packed {
    logic       idx;
    logic [2:0] len;
  } ord_t;

  sb_t  sb[$];
  ord_t ord[$];
  bit   m_sval;
  int   m_beat;
  int   n_cmp;
  int   n_err;
`ifdef SA_XADDR_RR_EN
  int   m_rr;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [1:0] v);
`ifdef SA_XADDR_RR_EN
    for (int k = 0; k < 2; k++) begin
      if (v[(m_rr + k) % 2]) return (m_rr + k) % 2;
    end
`else
    for (int k = 0; k < 2; k++) begin
      if (v[k]) return k;
    end
`endif
    return 0;
  endfunction

  // One clock: compare at the falling edge, advance the model, return 1 time unit after the rising edge
  task automatic step();
    logic [1:0] exp_rdy;
    int         g;
    bit         free;
    sb_t        e;
    @(negedge clk);
    free    = !m_sval || s_AxREADY_i;
    g       = pick(valid);
    exp_rdy = (free && valid != 2'b00 && ord.size() < 8) ? 2'(1 << g) : 2'b00;
    chk("dsp_ready", 64'(dsp_AxREADY_o), 64'(exp_rdy));
    chk("s_valid", 64'(s_AxVALID_o), 64'(m_sval));
    chk("outst_ctn", 64'(sa_outst_ctn_o), 64'(ord.size()));
    chk("disable", 64'(sa_xDATA_disable_o), 64'(ord.size() == 0));
    if (ord.size() > 0) chk("data_mst_id", 64'(sa_xDATA_mst_id_o), 64'(ord[0].idx));
    if (m_sval && sb.size() > 0) begin
      e = sb[0];
      chk("s_id", 64'(s_AxID_o), 64'(e.id));
      chk("s_addr", 64'(s_AxADDR_o), 64'(e.addr));
      chk("s_burst", 64'(s_AxBURST_o), 64'(e.burst));
      chk("s_len", 64'(s_AxLEN_o), 64'(e.len));
      chk("s_size", 64'(s_AxSIZE_o), 64'(e.size));
      if (s_AxREADY_i) e = sb.pop_front();
    end
    if (s_xVALID_i && s_xREADY_i && ord.size() > 0) begin
      if (m_beat == int'(ord[0].len)) begin
        void'(ord.pop_front());
        m_beat = 0;
      end else begin
        m_beat++;
      end
    end
    if (exp_rdy != 2'b00) begin
      e.id    = {1'(g), b_id[g]};
      e.addr  = b_addr[g];
      e.burst = b_burst[g];
      e.len   = b_len[g];
      e.size  = b_size[g];
      sb.push_back(e);
      ord.push_back({1'(g), b_len[g]});
      m_sval = 1'b1;
`ifdef SA_XADDR_RR_EN
      m_rr = (g + 1) % 2;
`endif
    end else if (s_AxREADY_i) begin
      m_sval = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; m_sval = 1'b0; m_beat = 0;
`ifdef SA_XADDR_RR_EN
    m_rr = 0;
`endif
    ARESET_i = 1'b1; valid = 2'b11; s_AxREADY_i = 1'b0;
    s_xVALID_i = 1'b0; s_xREADY_i = 1'b1;
    b_id[0] = 5'h05; b_addr[0] = 32'h1000; b_burst[0] = 2'd1; b_len[0] = 3'd3; b_size[0] = 3'd2;
    b_id[1] = 5'h1A; b_addr[1] = 32'h8000; b_burst[1] = 2'd2; b_len[1] = 3'd3; b_size[1] = 3'd3;

    // Reset state, with requests present during reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_valid", 64'(s_AxVALID_o), 64'd0);
    chk("rst_ctn", 64'(sa_outst_ctn_o), 64'd0);
    chk("rst_disable", 64'(sa_xDATA_disable_o), 64'd1);
    chk("rst_ready", 64'(dsp_AxREADY_o), 64'd0);
    @(negedge clk);
    ARESET_i = 1'b0; valid = 2'b00;
    @(posedge clk);
    #1;

    // First request from master 0 appears after one cycle
    valid = 2'b01; s_AxREADY_i = 1'b1;
    step();
    valid = 2'b00;
    chk("first_valid", 64'(s_AxVALID_o), 64'd1);
    chk("first_addr", 64'(s_AxADDR_o), 64'h1000);
    chk("first_id_msb", 64'(s_AxID_o[5]), 64'd0);
    chk("first_ctn", 64'(sa_outst_ctn_o), 64'd1);
    s_xVALID_i = 1'b1;
    repeat (4) step();
    s_xVALID_i = 1'b0;
    step();

    // Four-beat burst from master 1 drives the data-side owner, then releases it
    valid = 2'b10;
    step();
    valid = 2'b00;
    chk("m1_owner", 64'(sa_xDATA_mst_id_o), 64'd1);
    s_xVALID_i = 1'b1;
    repeat (4) step();
    s_xVALID_i = 1'b0;
    step();
    chk("m1_done_disable", 64'(sa_xDATA_disable_o), 64'd1);

    // Both masters are requesting; the grant pattern depends on the arbitration mode
    b_len[0] = 3'd0; b_len[1] = 3'd0;
    valid = 2'b11;
    repeat (4) step();
    valid = 2'b00;
    step();
    s_xVALID_i = 1'b1;
    repeat (4) step();
    s_xVALID_i = 1'b0;
    step();

    // Slave stall: the stage holds and no further request is accepted
    b_addr[0] = 32'h2000;
    valid = 2'b01; s_AxREADY_i = 1'b0;
    repeat (6) step();
    chk("stall_addr", 64'(s_AxADDR_o), 64'h2000);
    s_AxREADY_i = 1'b1;
    step();
    valid = 2'b00;
    step();
    s_xVALID_i = 1'b1;
    repeat (2) step();
    s_xVALID_i = 1'b0;
    step();

    // Fill the order FIFO, then free one slot with a beat
    valid = 2'b01;
    repeat (8) step();
    step();
    chk("full_ctn", 64'(sa_outst_ctn_o), 64'd8);
    s_xVALID_i = 1'b1;
    step();
    s_xVALID_i = 1'b0;
    chk("after_pop_ctn", 64'(sa_outst_ctn_o), 64'd7);
    step();
    valid = 2'b00;
    step();
    s_xVALID_i = 1'b1;
    repeat (8) step();
    s_xVALID_i = 1'b0;
    step();
    chk("drained_disable", 64'(sa_xDATA_disable_o), 64'd1);

    // Push and pop in the same cycle leave the count unchanged
    valid = 2'b01; s_xVALID_i = 1'b1;
    repeat (4) step();
    chk("pushpop_ctn", 64'(sa_outst_ctn_o), 64'd1);
    valid = 2'b00;
    step();
    s_xVALID_i = 1'b0;
    step();

    // Asynchronous reset mid-burst with three bursts outstanding
    b_len[0] = 3'd2; b_len[1] = 3'd2;
    valid = 2'b11;
    repeat (3) step();
    valid = 2'b00; s_AxREADY_i = 1'b0; s_xVALID_i = 1'b1;
    step();
    s_xVALID_i = 1'b0;
    chk("pre_rst_ctn", 64'(sa_outst_ctn_o), 64'd3);
    s_AxREADY_i = 1'b1; valid = 2'b01;
    #2;
    ARESET_i = 1'b1;
    #1;
    chk("arst_s_valid", 64'(s_AxVALID_o), 64'd0);
    chk("arst_ctn", 64'(sa_outst_ctn_o), 64'd0);
    chk("arst_disable", 64'(sa_xDATA_disable_o), 64'd1);
    chk("arst_ready", 64'(dsp_AxREADY_o), 64'd0);
    sb.delete(); ord.delete(); m_sval = 1'b0; m_beat = 0;
`ifdef SA_XADDR_RR_EN
    m_rr = 0;
`endif
    valid = 2'b00;
    @(negedge clk);
    ARESET_i = 1'b0;
    @(posedge clk);
    #1;

    // Operation after reset: pointer and beat counter start from zero
    valid = 2'b11;
    step();
    valid = 2'b00;
    step();
    s_xVALID_i = 1'b1;
    repeat (6) step();
    s_xVALID_i = 1'b0;
    step();
    chk("final_disable", 64'(sa_xDATA_disable_o), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
